// File: rtl/i2s_speaker_tx.sv
// Philips I2S transmitter: captures one L/R sample pair per 1024-clk frame and
// serialises it as 16-bit words in 32-bit slots, with MCLK/SCK/LRCK taken from a frame counter.
module i2s_speaker_tx #(
  parameter int MCLK_BIT = 1,
  parameter int SCK_BIT  = 3,
  parameter int LRCK_BIT = 9   // must be SCK_BIT+6 so each channel half holds 32 slots
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] audio_in_left,
  input  logic [15:0] audio_in_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        frame_start
);

  localparam int CW = LRCK_BIT + 1;

  logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [15:0]   shadow_l_q, shadow_l_d;
  logic [15:0]   shadow_r_q, shadow_r_d;
  logic          sdin_q, sdin_d;
  logic          frame_start_q, frame_start_d;

  logic          frame_end;
  logic          sck_end;
  logic [4:0]    slot_nxt;
  logic [3:0]    bit_sel;
  logic [15:0]   src;
  logic          slot_bit;

  assign cnt_nxt   = cnt_q + CW'(1);
  assign frame_end = &cnt_q;
  assign sck_end   = &cnt_q[SCK_BIT:0];

  // SDIN is loaded one clk ahead of the slot it carries, so decode the next count.
  assign slot_nxt  = cnt_nxt[LRCK_BIT-1:SCK_BIT+1];
  assign src       = cnt_nxt[LRCK_BIT] ? shadow_r_q : shadow_l_q;
  assign bit_sel   = 4'(5'd16 - slot_nxt);
  assign slot_bit  = (slot_nxt >= 5'd1 && slot_nxt <= 5'd16) ? src[bit_sel] : 1'b0;

  always_comb begin
    cnt_d         = '0;
    sdin_d        = 1'b0;
    frame_start_d = 1'b0;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;
    if (en) begin
      cnt_d         = cnt_nxt;
      sdin_d        = sdin_q;
      frame_start_d = frame_end;
      if (frame_end) begin
        shadow_l_d = audio_in_left;
        shadow_r_d = audio_in_right;
      end
      if (sck_end) sdin_d = slot_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      sdin_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      sdin_q        <= sdin_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign audio_mclk  = cnt_q[MCLK_BIT];
  assign audio_sck   = cnt_q[SCK_BIT];
  assign audio_lrck  = cnt_q[LRCK_BIT];
  assign audio_sdin  = sdin_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Bench for i2s_speaker_tx: per-cycle reference model of the pins plus
// table-driven frame decoding and hand sequences for enable and reset corners.
module tb_i2s_speaker_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] audio_in_left  = '0;
  logic [15:0] audio_in_right = '0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2s_speaker_tx dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .audio_in_left  (audio_in_left),
    .audio_in_right (audio_in_right),
    .audio_mclk     (audio_mclk),
    .audio_lrck     (audio_lrck),
    .audio_sck      (audio_sck),
    .audio_sdin     (audio_sdin),
    .frame_start    (frame_start)
  );

  // Reference model: position within the frame plus the pair currently playing.
  int          phase;
  logic [15:0] play_l, play_r;
  logic        fs_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0; play_l <= '0; play_r <= '0; fs_exp <= 1'b0;
    end else if (!en) begin
      phase <= 0; fs_exp <= 1'b0;
    end else if (phase == 1023) begin
      phase <= 0; play_l <= audio_in_left; play_r <= audio_in_right; fs_exp <= 1'b1;
    end else begin
      phase <= phase + 1; fs_exp <= 1'b0;
    end
  end

  function automatic logic [4:0] exp_pins(int p, logic [15:0] l, logic [15:0] r, logic fs);
    int          slot;
    logic [15:0] s;
    logic        sd;
    slot = (p % 512) / 16;
    s    = (p >= 512) ? r : l;
    sd   = (slot >= 1 && slot <= 16) ? s[16 - slot] : 1'b0;
    return {1'((p / 2) % 2), 1'((p / 8) % 2), 1'((p / 512) % 2), sd, fs};
  endfunction

  always @(negedge clk) begin
    logic [4:0] want, got;
    want = exp_pins(phase, play_l, play_r, fs_exp);
    got  = {audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start};
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL pins t=%0t phase=%0d got mclk/sck/lrck/sdin/fs=%b want %b", $time, phase, got, want);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_fs(output int cyc);
    bit ok;
    ok = 0; cyc = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_start) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_fs got timeout want frame_start within 2100 clk");
    end
  endtask

  // Starts at the negedge of cnt==0; decodes SDIN on SCK rising edges up to cnt==1016.
  task automatic collect(input int chg_at, input logic [15:0] chg_l,
                         output logic [31:0] lw, output logic [31:0] rw, output int nbits);
    logic prev;
    lw = '0; rw = '0; nbits = 0; prev = 1'b0;
    for (int i = 0; i <= 1016; i++) begin
      if (i == chg_at) audio_in_left = chg_l;
      if (audio_sck && !prev) begin
        if (audio_lrck) rw = {rw[30:0], audio_sdin};
        else            lw = {lw[30:0], audio_sdin};
        nbits++;
      end
      prev = audio_sck;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          chg_at;
    logic [15:0] chg_l;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] lw, rw;
    int          nb, cyc;

    vecs[0] = '{16'hA5C3, 16'h3C5A, -1,  16'h0000, 32'h52E1_8000, 32'h1E2D_0000};
    vecs[1] = '{16'h8000, 16'h0001, -1,  16'h0000, 32'h4000_0000, 32'h0000_8000};
    vecs[2] = '{16'hFFFF, 16'h0000, -1,  16'h0000, 32'h7FFF_8000, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'hFFFF, -1,  16'h0000, 32'h0000_0000, 32'h7FFF_8000};
    vecs[4] = '{16'hA5C3, 16'h3C5A, 100, 16'hFFFF, 32'h52E1_8000, 32'h1E2D_0000};
    vecs[5] = '{16'hFFFF, 16'h3C5A, -1,  16'h0000, 32'h7FFF_8000, 32'h1E2D_0000};
    vecs[6] = '{16'h7FFF, 16'h8001, -1,  16'h0000, 32'h3FFF_8000, 32'h4000_8000};

    repeat (3) @(negedge clk);
    chk("reset_pins", {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    audio_in_left  = 16'h1357;
    audio_in_right = 16'h2468;
    en = 1'b1;

    // Frame 0 plays the reset shadows.
    collect(-1, 16'h0, lw, rw, nb);
    chk("frame0_left", lw, 32'd0);
    chk("frame0_right", rw, 32'd0);
    chk("frame0_nbits", nb, 64);
    wait_fs(cyc);
    wait_fs(cyc);
    chk("fs_period", cyc, 1024);

    for (int k = 0; k < 7; k++) begin
      audio_in_left  = vecs[k].l;
      audio_in_right = vecs[k].r;
      wait_fs(cyc);
      collect(vecs[k].chg_at, vecs[k].chg_l, lw, rw, nb);
      chk($sformatf("vec%0d_left", k), lw, vecs[k].exp_l);
      chk($sformatf("vec%0d_right", k), rw, vecs[k].exp_r);
      chk($sformatf("vec%0d_nbits", k), nb, 64);
    end

    // Drop enable mid-frame; new inputs during idle must not reach the shadows.
    wait_fs(cyc);
    repeat (300) @(negedge clk);
    en = 1'b0;
    audio_in_left  = 16'h1111;
    audio_in_right = 16'h2222;
    @(posedge clk);
    #1;
    chk("idle_pins", {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start}, 32'd0);
    repeat (50) @(negedge clk);
    en = 1'b1;
    collect(-1, 16'h0, lw, rw, nb);
    chk("replay_left", lw, 32'h3FFF_8000);
    chk("replay_right", rw, 32'h4000_8000);

    // Async reset during the right-channel MSB.
    audio_in_left  = 16'hC001;
    audio_in_right = 16'h8001;
    wait_fs(cyc);
    repeat (530) @(negedge clk);
    chk("pre_reset_sdin", {31'd0, audio_sdin}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_pins", {27'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, frame_start}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    collect(-1, 16'h0, lw, rw, nb);
    chk("post_reset_left", lw, 32'd0);
    chk("post_reset_right", rw, 32'd0);
    wait_fs(cyc);
    collect(-1, 16'h0, lw, rw, nb);
    chk("post_reset2_left", lw, 32'h6000_8000);
    chk("post_reset2_right", rw, 32'h4000_8000);

    // Random inputs and enable drops, checked cycle by cycle against the model.
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      audio_in_left  = 16'($urandom);
      audio_in_right = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        en = 1'b1;
      end
    end
    repeat (2100) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
